seq_multiplier: RTL and testbench

//   Parametrised iterative shift-add multiplier: one multiplier bit per clock, WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/seq_multiplier.sv | 113 +++++++++++
 tb/tb_seq_multiplier.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH x WIDTH -> 2*WIDTH.
// Supports signed/unsigned operands, optional early termination and abort.
module seq_multiplier #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mult_begin,
    input  logic                 mult_signed,
    input  logic [WIDTH-1:0]     mult_op1,
    input  logic [WIDTH-1:0]     mult_op2,
    output logic [2*WIDTH-1:0]   product,
    output logic                 mult_busy,
    output logic                 mult_end
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic [WIDTH-1:0]     op1_abs;
    logic [WIDTH-1:0]     op2_abs;
    logic [WIDTH-1:0]     mplier_shift;
    logic                 calc_last;

    // Magnitudes fit in WIDTH unsigned bits, including |-2^(W-1)|
    always_comb begin
        op1_abs      = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
        op2_abs      = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;
        mplier_shift = mplier >> 1;
        calc_last    = (cnt == CNT_W'(WIDTH - 1)) ||
                       ((EARLY_EXIT != 1'b0) && (mplier_shift == '0));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mult_begin) state_next = CALC;
            CALC: begin
                if (!mult_begin) begin
                    state_next = IDLE;
                end else if (calc_last) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = mult_begin ? DONE : IDLE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mult_busy = (state == CALC) || (state == FIX);
        mult_end  = (state == DONE);
    end

    // An abort edge (mult_begin low in CALC/FIX) leaves all registers untouched
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_begin) begin
                        mcand  <= {{WIDTH{1'b0}}, op1_abs};
                        mplier <= op2_abs;
                        neg    <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (mult_begin) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier_shift;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (mult_begin) begin
                        product <= neg ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks of seq_multiplier, W=32, with and without early exit.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        begin0 = 1'b0;
    logic        begin_ee = 1'b0;
    logic        sgn_in = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] product0, product_ee;
    logic        busy0, busy_ee, end0, end_ee;
    bit          sel = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cycle = 0;

    logic [63:0] cur_product;
    logic        cur_end, cur_busy;

    assign cur_product = sel ? product_ee : product0;
    assign cur_end     = sel ? end_ee : end0;
    assign cur_busy    = sel ? busy_ee : busy0;

    seq_multiplier #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut (
        .clk(clk), .resetn(resetn), .mult_begin(begin0), .mult_signed(sgn_in),
        .mult_op1(op1), .mult_op2(op2), .product(product0),
        .mult_busy(busy0), .mult_end(end0)
    );

    seq_multiplier #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .resetn(resetn), .mult_begin(begin_ee), .mult_signed(sgn_in),
        .mult_op1(op1), .mult_op2(op2), .product(product_ee),
        .mult_busy(busy_ee), .mult_end(end_ee)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Runs one operation and returns product, edges from accept to mult_end, and mult_end one cycle later
    task automatic do_op(input bit use_ee, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod, output int lat, output logic end_after);
        int n;
        bit seen;
        sel = use_ee;
        @(negedge clk);
        op1 = a;
        op2 = b;
        sgn_in = sgn;
        if (use_ee) begin_ee = 1'b1;
        else begin0 = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (cur_end) seen = 1'b1;
        end
        prod = cur_product;
        lat = n - 1;
        begin0 = 1'b0;
        begin_ee = 1'b0;
        @(negedge clk);
        end_after = cur_end;
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL op_timeout: no mult_end after %0d edges, required a pulse", n);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (product0 !== 64'h0 || product_ee !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_product: got %h / %h, required 0", product0, product_ee);
        end
        n_cmp++;
        if (busy0 !== 1'b0 || busy_ee !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b / %b, required 0", busy0, busy_ee);
        end
        n_cmp++;
        if (end0 !== 1'b0 || end_ee !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_end: got %b / %b, required 0", end0, end_ee);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [63:0] p;
        int lat;
        logic ea;
        do_op(1'b0, 1'b0, 32'h11111111, 32'h22222222, p, lat, ea);
        n_cmp++;
        if (p !== 64'h02468ACF0ECA8642) begin
            n_fail++;
            $display("FAIL unsigned_product: got %h, required 02468acf0eca8642", p);
        end
        n_cmp++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL unsigned_latency: got %0d edges, required 33", lat);
        end
        n_cmp++;
        if (ea !== 1'b0) begin
            n_fail++;
            $display("FAIL end_pulse_width: mult_end still %b one cycle later, required 0", ea);
        end
    endtask

    task automatic test_signed();
        logic [63:0] p;
        int lat;
        logic ea;
        do_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000002, p, lat, ea);
        n_cmp++;
        if (p !== 64'hFFFFFFFFFFFFFFFE) begin
            n_fail++;
            $display("FAIL signed_neg1x2: got %h, required fffffffffffffffe", p);
        end
        do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, p, lat, ea);
        n_cmp++;
        if (p !== 64'h00000001FFFFFFFE) begin
            n_fail++;
            $display("FAIL unsigned_ffx2: got %h, required 00000001fffffffe", p);
        end
        do_op(1'b0, 1'b1, 32'h80000000, 32'h80000000, p, lat, ea);
        n_cmp++;
        if (p !== 64'h4000000000000000) begin
            n_fail++;
            $display("FAIL signed_minsq: got %h, required 4000000000000000", p);
        end
        do_op(1'b0, 1'b1, 32'h80000000, 32'h00000001, p, lat, ea);
        n_cmp++;
        if (p !== 64'hFFFFFFFF80000000) begin
            n_fail++;
            $display("FAIL signed_minx1: got %h, required ffffffff80000000", p);
        end
    endtask

    task automatic test_abort();
        logic [63:0] p;
        int lat;
        logic ea;
        int ends_seen;
        do_op(1'b0, 1'b0, 32'd5, 32'd7, p, lat, ea);
        n_cmp++;
        if (p !== 64'd35) begin
            n_fail++;
            $display("FAIL abort_setup: got %h, required 35", p);
        end
        sel = 1'b0;
        @(negedge clk);
        op1 = 32'h00001234;
        op2 = 32'h00005678;
        begin0 = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_before: got %b, required 1", busy0);
        end
        begin0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy_after: got %b, required 0", busy0);
        end
        ends_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (end0 === 1'b1) ends_seen++;
        end
        n_cmp++;
        if (ends_seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_end: got %0d pulses, required 0", ends_seen);
        end
        n_cmp++;
        if (product0 !== 64'd35) begin
            n_fail++;
            $display("FAIL abort_product_held: got %h, required 35", product0);
        end
    endtask

    task automatic test_async_reset();
        sel = 1'b0;
        @(negedge clk);
        op1 = 32'h0000FFFF;
        op2 = 32'h00000003;
        begin0 = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (product0 !== 64'h0 || busy0 !== 1'b0 || end0 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got product=%h busy=%b end=%b, required all 0",
                     product0, busy0, end0);
        end
        begin0 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy got %b, required 0", busy0);
        end
    endtask

    task automatic test_early_exit();
        logic [63:0] p;
        int lat;
        logic ea;
        do_op(1'b1, 1'b0, 32'h00001234, 32'h00000003, p, lat, ea);
        n_cmp++;
        if (p !== 64'h000000000000369C) begin
            n_fail++;
            $display("FAIL ee_product: got %h, required 369c", p);
        end
        n_cmp++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL ee_latency: got %0d edges, required 3", lat);
        end
        do_op(1'b1, 1'b0, 32'h00001234, 32'h00000000, p, lat, ea);
        n_cmp++;
        if (p !== 64'h0) begin
            n_fail++;
            $display("FAIL ee_zero_product: got %h, required 0", p);
        end
        n_cmp++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL ee_zero_latency: got %0d edges, required 2", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_v [3] = '{32'd3, 32'hFFFFFFFD, 32'h00010000};
        logic [31:0] b_v [3] = '{32'd5, 32'd7, 32'h00010000};
        bit          s_v [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] e_v [3] = '{64'd15, 64'hFFFFFFFFFFFFFFEB, 64'h0000000100000000};
        int t_end [3];
        int k;
        int n;
        sel = 1'b0;
        @(negedge clk);
        op1 = a_v[0];
        op2 = b_v[0];
        sgn_in = s_v[0];
        begin0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op1 = 32'hDEADBEEF;
        op2 = 32'hCAFEF00D;
        sgn_in = ~s_v[0];
        k = 0;
        n = 0;
        while (k < 3 && n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (end0) begin
                t_end[k] = cycle;
                n_cmp++;
                if (product0 !== e_v[k]) begin
                    n_fail++;
                    $display("FAIL b2b_product_%0d: got %h, required %h", k, product0, e_v[k]);
                end
                k++;
                if (k < 3) begin
                    op1 = a_v[k];
                    op2 = b_v[k];
                    sgn_in = s_v[k];
                    repeat (2) @(posedge clk);
                    @(negedge clk);
                    op1 = 32'hDEADBEEF;
                    op2 = 32'hCAFEF00D;
                    sgn_in = ~s_v[k];
                end else begin
                    begin0 = 1'b0;
                end
            end
        end
        begin0 = 1'b0;
        n_cmp++;
        if (k !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, required 3", k);
        end else begin
            n_cmp++;
            if (t_end[1] - t_end[0] !== 35 || t_end[2] - t_end[1] !== 35) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d and %0d cycles, required 35",
                         t_end[1] - t_end[0], t_end[2] - t_end[1]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] p;
        logic [63:0] exp_p;
        logic signed [63:0] sa, sb;
        logic [31:0] a, b;
        bit sgn;
        int lat;
        logic ea;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            sgn = 1'($urandom_range(0, 1));
            if (sgn) begin
                sa = $signed({{32{a[31]}}, a});
                sb = $signed({{32{b[31]}}, b});
                exp_p = sa * sb;
            end else begin
                exp_p = {32'b0, a} * {32'b0, b};
            end
            do_op(i[0], sgn, a, b, p, lat, ea);
            n_cmp++;
            if (p !== exp_p) begin
                n_fail++;
                $display("FAIL random_%0d: %h*%h signed=%0b got %h, required %h",
                         i, a, b, sgn, p, exp_p);
            end
        end
    endtask

    initial begin
        $display("[TB] starting seq_multiplier bench");
        test_reset();
        test_unsigned();
        test_signed();
        test_abort();
        test_async_reset();
        test_early_exit();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
